// File: rtl/iob2axi_rd_pkg.sv
// Shared AXI4 field widths and the FSM encoding for the IOb-to-AXI4 read master.
package iob2axi_rd_pkg;

    localparam int AXI_ID_W    = 1;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_LOCK_W  = 2;
    localparam int AXI_CACHE_W = 4;
    localparam int AXI_PROT_W  = 3;
    localparam int AXI_QOS_W   = 4;
    localparam int AXI_RESP_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR_HS = 2'd1,
        ST_READ    = 2'd2
    } rd_state_e;

endpackage

// File: rtl/iob2axi_rd.sv
// Native read request -> single AXI4 INCR read burst; beats streamed back
// to the native consumer with zero-latency rready/s_ready.
module iob2axi_rd
    import iob2axi_rd_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int AXI_ADDR_W = ADDR_W,
    parameter int AXI_DATA_W = DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   run,
    input  logic [AXI_LEN_W-1:0]   length,
    output logic                   ready,
    output logic                   error,

    input  logic                   s_valid,
    input  logic [ADDR_W-1:0]      s_addr,
    output logic [DATA_W-1:0]      s_rdata,
    output logic                   s_ready,

    output logic [AXI_ID_W-1:0]    m_axi_arid,
    output logic [AXI_ADDR_W-1:0]  m_axi_araddr,
    output logic [AXI_LEN_W-1:0]   m_axi_arlen,
    output logic [AXI_SIZE_W-1:0]  m_axi_arsize,
    output logic [AXI_BURST_W-1:0] m_axi_arburst,
    output logic [AXI_LOCK_W-1:0]  m_axi_arlock,
    output logic [AXI_CACHE_W-1:0] m_axi_arcache,
    output logic [AXI_PROT_W-1:0]  m_axi_arprot,
    output logic [AXI_QOS_W-1:0]   m_axi_arqos,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,

    input  logic [AXI_ID_W-1:0]    m_axi_rid,
    input  logic [AXI_DATA_W-1:0]  m_axi_rdata,
    input  logic [AXI_RESP_W-1:0]  m_axi_rresp,
    input  logic                   m_axi_rlast,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready
);

    rd_state_e              state_q;
    logic [AXI_ADDR_W-1:0]  addr_q;
    logic [AXI_LEN_W-1:0]   length_q;
    logic [AXI_LEN_W:0]     counter_q;
    logic                   error_q;

    logic                   beat;
    logic                   last_beat;
    logic                   beat_bad;
    logic                   unused_rid;

    assign unused_rid = ^m_axi_rid;

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = length_q;
    assign m_axi_arsize  = AXI_SIZE_W'($clog2(DATA_W / 8));
    assign m_axi_arburst = AXI_BURST_W'(1);
    assign m_axi_arlock  = '0;
    assign m_axi_arcache = AXI_CACHE_W'(2);
    assign m_axi_arprot  = AXI_PROT_W'(2);
    assign m_axi_arqos   = '0;

    // Handshake outputs decode straight from the state register so that an
    // asynchronous reset drops them without waiting for a clock edge.
    assign ready         = (state_q == ST_IDLE);
    assign m_axi_arvalid = (state_q == ST_ADDR_HS);
    assign m_axi_rready  = (state_q == ST_READ) & s_valid;
    assign s_ready       = m_axi_rvalid & m_axi_rready;
    assign s_rdata       = DATA_W'(m_axi_rdata);
    assign error         = error_q;

    assign beat      = m_axi_rvalid & m_axi_rready;
    assign last_beat = (counter_q == {1'b0, length_q});
    assign beat_bad  = (m_axi_rresp != '0) | (m_axi_rlast != last_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            length_q  <= '0;
            counter_q <= '0;
            error_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        addr_q    <= AXI_ADDR_W'(s_addr);
                        length_q  <= length;
                        counter_q <= '0;
                        error_q   <= 1'b0;
                        state_q   <= ST_ADDR_HS;
                    end
                end
                ST_ADDR_HS: begin
                    if (m_axi_arready) begin
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Bad rlast/rresp flags the burst but the count still ends it.
                    if (beat) begin
                        counter_q <= counter_q + 1'b1;
                        if (beat_bad) begin
                            error_q <= 1'b1;
                        end
                        if (last_beat) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob2axi_rd.sv
// Directed bench for iob2axi_rd: a table of burst scenarios driven by one
// burst task, plus reset-state and mid-burst reset sequences.
module tb_iob2axi_rd;
    import iob2axi_rd_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   run;
    logic [AXI_LEN_W-1:0]   length;
    logic                   ready;
    logic                   error;
    logic                   s_valid;
    logic [ADDR_W-1:0]      s_addr;
    logic [DATA_W-1:0]      s_rdata;
    logic                   s_ready;
    logic [AXI_ID_W-1:0]    arid;
    logic [ADDR_W-1:0]      araddr;
    logic [AXI_LEN_W-1:0]   arlen;
    logic [AXI_SIZE_W-1:0]  arsize;
    logic [AXI_BURST_W-1:0] arburst;
    logic [AXI_LOCK_W-1:0]  arlock;
    logic [AXI_CACHE_W-1:0] arcache;
    logic [AXI_PROT_W-1:0]  arprot;
    logic [AXI_QOS_W-1:0]   arqos;
    logic                   arvalid;
    logic                   arready;
    logic [AXI_ID_W-1:0]    rid;
    logic [DATA_W-1:0]      rdata;
    logic [AXI_RESP_W-1:0]  rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;

    int n_total = 0;
    int n_pass  = 0;

    iob2axi_rd #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .length       (length),
        .ready        (ready),
        .error        (error),
        .s_valid      (s_valid),
        .s_addr       (s_addr),
        .s_rdata      (s_rdata),
        .s_ready      (s_ready),
        .m_axi_arid   (arid),
        .m_axi_araddr (araddr),
        .m_axi_arlen  (arlen),
        .m_axi_arsize (arsize),
        .m_axi_arburst(arburst),
        .m_axi_arlock (arlock),
        .m_axi_arcache(arcache),
        .m_axi_arprot (arprot),
        .m_axi_arqos  (arqos),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rid    (rid),
        .m_axi_rdata  (rdata),
        .m_axi_rresp  (rresp),
        .m_axi_rlast  (rlast),
        .m_axi_rvalid (rvalid),
        .m_axi_rready (rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          ar_delay;
        bit          toggle;
        int          resp_beat;
        int          rlast_beat;
        int          abort_after;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input vec_t v);
        int beats;
        int cyc;
        logic sv;
        chk("idle_ready", ready, 1);
        s_valid = 1'b1;
        rvalid  = 1'b0;
        #1;
        chk("idle_rready", rready, 0);
        run    = 1'b1;
        s_addr = v.addr;
        length = AXI_LEN_W'(v.len);
        step();
        run    = 1'b0;
        s_addr = 32'hDEAD_BEEF;
        length = 8'hFF;
        #1;
        chk("run_ready", ready, 0);
        chk("run_err_clr", error, 0);
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, v.addr);
        chk("arlen", arlen, 64'(v.len));
        for (int d = 0; d < v.ar_delay; d++) begin
            arready = 1'b0;
            #1;
            chk("arvalid_hold", arvalid, 1);
            chk("araddr_hold", araddr, v.addr);
            chk("arlen_hold", arlen, 64'(v.len));
            chk("rready_ar", rready, 0);
            step();
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        #1;
        chk("arvalid_drop", arvalid, 0);
        beats = 0;
        cyc   = 0;
        while (beats <= v.len && cyc < 100) begin
            if (v.abort_after >= 0 && beats == v.abort_after) begin
                s_valid = 1'b1;
                rvalid  = 1'b1;
                rst     = 1'b1;
                #1;
                chk("rst_ready", ready, 1);
                chk("rst_arvalid", arvalid, 0);
                chk("rst_rready", rready, 0);
                chk("rst_sready", s_ready, 0);
                rst    = 1'b0;
                rvalid = 1'b0;
                step();
                return;
            end
            sv      = v.toggle ? (cyc % 2 == 0) : 1'b1;
            s_valid = sv;
            rvalid  = 1'b1;
            rdata   = v.addr + 32'(beats * 16);
            rresp   = (beats == v.resp_beat) ? 2'd2 : 2'd0;
            rlast   = (beats == v.rlast_beat);
            #1;
            chk("busy_ready", ready, 0);
            chk("rready", rready, sv);
            chk("s_ready", s_ready, sv);
            if (sv) chk("s_rdata", s_rdata, v.addr + 32'(beats * 16));
            step();
            if (sv) beats++;
            cyc++;
        end
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rresp   = 2'd0;
        s_valid = 1'b0;
        #1;
        chk("beats", 64'(beats), 64'(v.len + 1));
        chk("done_ready", ready, 1);
        chk("done_error", error, v.exp_err);
        step();
    endtask

    vec_t vecs[9];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h100, 3, 0, 0, -1,  3, -1, 0};
        vecs[1] = '{32'h200, 3, 5, 0, -1,  3, -1, 0};
        vecs[2] = '{32'h300, 7, 0, 1, -1,  7, -1, 0};
        vecs[3] = '{32'h400, 3, 0, 0,  1,  3, -1, 1};
        vecs[4] = '{32'h500, 3, 0, 0, -1,  3, -1, 0};
        vecs[5] = '{32'h600, 3, 0, 0, -1,  1, -1, 1};
        vecs[6] = '{32'h700, 2, 0, 0, -1, -1, -1, 1};
        vecs[7] = '{32'h800, 0, 2, 0, -1,  0, -1, 0};
        vecs[8] = '{32'h900, 3, 0, 0, -1,  3,  1, 0};

        rst     = 1'b1;
        run     = 1'b0;
        length  = '0;
        s_addr  = '0;
        s_valid = 1'b1;
        arready = 1'b0;
        rid     = '0;
        rdata   = '0;
        rresp   = '0;
        rlast   = 1'b0;
        rvalid  = 1'b1;
        #12;
        chk("rst_ready0", ready, 1);
        chk("rst_error0", error, 0);
        chk("rst_arvalid0", arvalid, 0);
        chk("rst_rready0", rready, 0);
        chk("rst_sready0", s_ready, 0);
        chk("rst_araddr0", araddr, 0);
        chk("rst_arlen0", arlen, 0);
        chk("arsize", arsize, 2);
        chk("arburst", arburst, 1);
        chk("arcache", arcache, 2);
        chk("arprot", arprot, 2);
        chk("arid_qos_lock", {arid, arqos, arlock}, 0);
        rvalid  = 1'b0;
        s_valid = 1'b0;
        #1;
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            burst(vecs[i]);
            if (i == 3) chk("err_sticky", error, 1);
        end

        // Run pulse while busy must be ignored.
        run = 1'b1;
        s_addr = 32'hA00;
        length = 8'd1;
        step();
        s_addr = 32'hB00;
        length = 8'd5;
        step();
        run = 1'b0;
        #1;
        chk("busy_run_addr", araddr, 32'hA00);
        chk("busy_run_len", arlen, 1);
        arready = 1'b1;
        step();
        arready = 1'b0;
        s_valid = 1'b1;
        rvalid  = 1'b1;
        rlast   = 1'b0;
        step();
        rlast = 1'b1;
        step();
        rvalid  = 1'b0;
        rlast   = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("busy_run_done", ready, 1);
        chk("busy_run_err", error, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iob2axi_rd.md
# iob2axi_rd

Converts a single native-interface read request into one AXI4 INCR read burst and streams the returned beats back to the native side. Pairs with the existing native-to-AXI write master; the two together form the IOb-to-AXI4 full master bridge. Sits between a DMA-style native consumer and the AXI interconnect.

## Interface
- ADDR_W, 0, native address width
- DATA_W, 0, native data width (bytes = DATA_W/8, power of two)
- AXI_ADDR_W, ADDR_W, AXI address width
- AXI_DATA_W, DATA_W, AXI data width (equal to DATA_W)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  start pulse, sampled only when ready=1
- length  in  AXI_LEN_W  burst length minus one (arlen)
- ready  out  1  idle, accepting run
- error  out  1  sticky error of last burst
- s_valid  in  1  consumer can take a beat (drives rready)
- s_addr  in  ADDR_W  burst start address, sampled with run
- s_rdata  out  DATA_W  beat data (= m_axi_rdata)
- s_ready  out  1  beat delivered this cycle
- m_axi_arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid  out  standard widths from axi.vh  AR channel
- m_axi_arready  in  1
- m_axi_rid, rdata, rresp, rlast, rvalid  in  standard widths  R channel
- m_axi_rready  out  1

## Operation
- Constant AR fields: arid=0, arsize=$clog2(DATA_W/8), arburst=1 (INCR), arlock=0, arcache=2, arprot=2, arqos=0. araddr/arlen from registers addr_reg/length_reg.
- States: IDLE, ADDR_HS, READ. Unknown state -> IDLE.
- IDLE: ready=1. On run: latch s_addr, length; clear error and counter; -> ADDR_HS.
- ADDR_HS: arvalid=1, held with stable araddr/arlen until arready; on arvalid&arready -> READ.
- READ: m_axi_rready = s_valid; s_ready = rvalid & s_valid; beat accepted on rvalid&rready; counter (AXI_LEN_W+1 bits) increments per beat.
- Final beat: counter == length_reg. On it -> IDLE.
- error set (sticky until next run) if any accepted beat has rresp != 0, or rlast disagrees with final-beat condition (rlast early or missing on final beat). Burst still completes by count.
- run while not IDLE ignored. No outstanding-transaction overlap: one burst at a time.

## Timing
- Reset values: ready=1, error=0, arvalid=0, rready=0, s_ready=0, counter=0, state IDLE, addr_reg/length_reg=0.
- run at cycle 0 -> ready=0, arvalid=1 from cycle 1 (all registered state).
- arready in cycle k -> arvalid=0 and READ from k+1; rready never asserted before READ.
- s_rdata/s_ready/rready combinational in READ (zero latency from rvalid/s_valid).
- Final beat at cycle n -> ready=1 and error valid at n+1; new run accepted at n+1.
- rvalid with s_valid=0: no acceptance, counter holds (backpressure).
- Reset mid-burst: immediate return to IDLE, arvalid/rready drop asynchronously; interconnect must be reset together.

## Structure
- AXI widths/port macros (AXI_LEN_W, AXI_ID_W, AXI_BURST_W, AXI4_M_READ_IF_PORT) from shared axi.vh; no new package constants except local state encodings.
- Single flat module; no sub-module.

## Test plan
- run, s_addr=0x100, length=3, arready same cycle, 4 beats back-to-back, rlast on 4th -> arlen=3, araddr=0x100, 4 s_ready pulses, ready=1 one cycle after beat 4, error=0.
- arready delayed 5 cycles -> arvalid held 5 cycles, araddr/arlen stable, rready=0 throughout.
- length=7, s_valid toggling 1/0 -> exactly 8 beats accepted, counter stalls on s_valid=0, data order preserved.
- beat 2 of 4 with rresp=2 (SLVERR) -> error=1 after burst; next run clears error to 0.
- length=3, rlast on beat 2 -> error=1, block still consumes 4 beats then ready=1.
- rst asserted mid-READ after beat 1 -> ready=1, arvalid=0, rready=0 immediately; new run afterwards completes normally.
